// File: rtl/hadamard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hadamard_pkg
//  Purpose  : Shared defaults and element/vector types for the Hadamard unit.
//  Revision : 1.0 - initial release
// ============================================================================
package hadamard_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SIZE  = 9;

    typedef logic signed [DEF_WIDTH-1:0] elem_t;
    typedef elem_t [DEF_SIZE-1:0]        vec_t;

endpackage : hadamard_pkg
`default_nettype wire

// File: rtl/hadamard_lane.sv
`default_nettype none
// ============================================================================
//  Module   : hadamard_lane
//  Purpose  : One signed multiply, result truncated to the operand width.
//  Revision : 1.0 - initial release
// ============================================================================
module hadamard_lane
    import hadamard_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_p
);

    // Low WIDTH bits of a two's-complement product are sign-agnostic; wraps silently.
    assign o_p = i_a * i_b;

endmodule : hadamard_lane
`default_nettype wire

// File: rtl/hadamard_product_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hadamard_product_unit
//  Purpose  : Two-stage pipelined element-wise kernel x patch product with
//             valid/ready handshakes on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module hadamard_product_unit
    import hadamard_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZE  = DEF_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SIZE-1:0][WIDTH-1:0]  kernel,
    input  logic [SIZE-1:0][WIDTH-1:0]  patch,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SIZE-1:0][WIDTH-1:0]  res
);

    logic                        r_s1_valid;
    logic [SIZE-1:0][WIDTH-1:0]  r_s1_kernel;
    logic [SIZE-1:0][WIDTH-1:0]  r_s1_patch;
    logic                        r_s2_valid;
    logic [SIZE-1:0][WIDTH-1:0]  r_res;
    logic [SIZE-1:0][WIDTH-1:0]  w_prod;
    logic                        w_stall;

    // Whole pipe freezes while the output holds data that has not been taken.
    assign w_stall   = r_s2_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_s2_valid;
    assign res       = r_res;

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
        hadamard_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .i_a (r_s1_kernel[gi]),
            .i_b (r_s1_patch[gi]),
            .o_p (w_prod[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_kernel <= '0;
            r_s1_patch  <= '0;
            r_s2_valid  <= 1'b0;
            r_res       <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_kernel <= kernel;
                r_s1_patch  <= patch;
            end
            r_s2_valid <= r_s1_valid;
            // Bubbles leave res untouched; only real vectors overwrite it.
            if (r_s1_valid) begin
                r_res <= w_prod;
            end
        end
    end

endmodule : hadamard_product_unit
`default_nettype wire

// File: tb/tb_hadamard_product_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hadamard_product_unit
//  Purpose  : Directed, table-driven bench for hadamard_product_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hadamard_product_unit;

    localparam int W = 32;
    localparam int S = 9;

    typedef logic [S-1:0][W-1:0] vec_t;
    typedef struct {
        string name;
        vec_t  k;
        vec_t  p;
        vec_t  e;
    } tv_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    vec_t kernel;
    vec_t patch;
    logic out_valid;
    logic out_ready;
    vec_t res;

    int   n_tests = 0;
    int   n_fail  = 0;
    tv_t  tv[4];
    vec_t bp_k[4];
    vec_t bp_p[4];
    vec_t bp_e[4];

    always #5 clk = ~clk;

    hadamard_product_unit #(.WIDTH(W), .SIZE(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kernel    (kernel),
        .patch     (patch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    task automatic check(input string nm, input logic [S*W-1:0] act, input logic [S*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply_vec(input tv_t t);
        @(negedge clk);
        in_valid  = 1'b1;
        kernel    = t.k;
        patch     = t.p;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({t.name, "_lat1_valid"}, {{(S*W-1){1'b0}}, out_valid}, '0);
        @(negedge clk);
        check({t.name, "_lat2_valid"}, {{(S*W-1){1'b0}}, out_valid}, 1);
        check({t.name, "_res"}, res, t.e);
    endtask

    initial begin
        int   n_in;
        int   n_out;
        int   n_stall;
        int   cyc;
        vec_t v;

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 4; i++) begin
            tv[i].k = '0; tv[i].p = '0; tv[i].e = '0;
        end
        tv[0].name = "basic";
        for (int i = 0; i < S; i++) begin
            tv[0].k[i] = W'(i + 1);
            tv[0].p[i] = 32'd2;
            tv[0].e[i] = W'(2 * (i + 1));
        end
        tv[1].name = "zero";
        tv[2].name = "sign";
        tv[2].k[0] = -32'sd3;          tv[2].p[0] = 32'd7;  tv[2].e[0] = 32'hFFFF_FFEB;
        tv[2].k[1] = -32'sd4;          tv[2].p[1] = -32'sd5; tv[2].e[1] = 32'd20;
        tv[3].name = "ovf";
        tv[3].k[0] = 32'h0001_0000;    tv[3].p[0] = 32'h0001_0000; tv[3].e[0] = 32'h0;
        tv[3].k[1] = 32'h7FFF_FFFF;    tv[3].p[1] = 32'd2;         tv[3].e[1] = 32'hFFFF_FFFE;
        tv[3].k[2] = 32'hFFFF_FFFF;    tv[3].p[2] = 32'hFFFF_FFFF; tv[3].e[2] = 32'h1;
        tv[3].k[3] = 32'h8000_0000;    tv[3].p[3] = 32'hFFFF_FFFF; tv[3].e[3] = 32'h8000_0000;

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < S; i++) begin
                bp_k[n][i] = W'(i + 1);
                bp_p[n][i] = W'(n + 2);
                bp_e[n][i] = W'((i + 1) * (n + 2));
            end
        end

        // ---------------- reset with in_valid held high ----------------
        rst       = 1'b1;
        in_valid  = 1'b1;
        kernel    = tv[0].k;
        patch     = tv[0].p;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_out_valid", {{(S*W-1){1'b0}}, out_valid}, '0);
            check("rst_res", res, '0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", {{(S*W-1){1'b0}}, in_ready}, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_no_output", {{(S*W-1){1'b0}}, out_valid}, '0);
        end

        // ---------------- table-driven products ----------------
        for (int t = 0; t < 4; t++) apply_vec(tv[t]);

        // ---------------- backpressure: 4 back-to-back, 3-cycle stall ----------------
        n_in = 0; n_out = 0; n_stall = 0; cyc = 0;
        while (n_out < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            out_ready = (n_out == 1 && n_stall < 3) ? 1'b0 : 1'b1;
            in_valid  = (n_in < 4);
            if (n_in < 4) begin
                kernel = bp_k[n_in];
                patch  = bp_p[n_in];
            end
            #1;
            if (out_valid && !out_ready) begin
                n_stall++;
                check("bp_stall_in_ready", {{(S*W-1){1'b0}}, in_ready}, '0);
                check("bp_stall_res_stable", res, bp_e[n_out]);
            end
            if (out_valid && out_ready) begin
                check("bp_res_order", res, bp_e[n_out]);
                n_out++;
            end
            if (in_valid && in_ready) n_in++;
        end
        check("bp_all_outputs", 32'(n_out), 32'd4);
        check("bp_stall_cycles", 32'(n_stall), 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_no_duplicate", {{(S*W-1){1'b0}}, out_valid}, '0);
        end

        // ---------------- mid-stream reset ----------------
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        kernel    = bp_k[0];
        patch     = bp_p[0];
        @(negedge clk);
        kernel = bp_k[1];
        patch  = bp_p[1];
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("mid_rst_flushed", {{(S*W-1){1'b0}}, out_valid}, '0);
            @(negedge clk);
        end
        v = tv[2].e;
        in_valid = 1'b1;
        kernel   = tv[2].k;
        patch    = tv[2].p;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_rst_lat1_valid", {{(S*W-1){1'b0}}, out_valid}, '0);
        @(negedge clk);
        check("mid_rst_lat2_valid", {{(S*W-1){1'b0}}, out_valid}, 1);
        check("mid_rst_res", res, v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hadamard_product_unit
`default_nettype wire

// File: doc/hadamard_product_unit.md
Name: hadamard_product_unit

Overview:
- Element-wise (Hadamard) product of a SIZE-element convolution kernel and a same-sized image patch.
- Each lane multiplies kernel[i] by patch[i]; all lanes run in parallel.
- Sits ahead of the accumulation/adder tree in the convolution accelerator's multiple-unit datapath.
- Pipelined, with valid/ready handshakes on input and output.

Parameters:
- WIDTH, 32, bit width of each element (operands and products).
- SIZE, 9, number of elements per vector (3x3 kernel).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  kernel/patch are valid this cycle.
- in_ready  output  1  unit accepts an input this cycle.
- kernel  input  SIZE*WIDTH (packed [SIZE-1:0][WIDTH-1:0])  kernel elements; element i at [i].
- patch  input  SIZE*WIDTH (packed [SIZE-1:0][WIDTH-1:0])  patch elements; element i at [i].
- out_valid  output  1  res holds a valid product vector.
- out_ready  input  1  downstream accepts res this cycle.
- res  output  SIZE*WIDTH (packed [SIZE-1:0][WIDTH-1:0])  products; res[i] = kernel[i]*patch[i].

Behaviour:
- Arithmetic:
  - Operands are signed two's complement.
  - res[i] is the low WIDTH bits of the full signed product kernel[i]*patch[i]; overflow wraps silently, with no saturation and no flag.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline: two register stages.
  - S1 registers the operands and a valid bit.
  - S2 registers the products and a valid bit; S2 drives res and out_valid.
- Latency: exactly 2 clk cycles from input transfer to out_valid, when there is no backpressure.
- Throughput: one vector per cycle while out_ready is held high.
- Stall rule:
  - stall = out_valid && !out_ready.
  - During a stall, S1 and S2 hold their contents.
  - in_ready = !stall (combinational).
  - res and out_valid stay stable while out_valid && !out_ready.
- Bubbles:
  - When S1 is empty, S2 loads valid=0 on the next non-stalled edge.
  - res holds its last value when out_valid=0; downstream must not sample it.
- Reset (rst=1 at a rising edge):
  - Both valid bits cleared; out_valid=0.
  - res and S1 operand registers cleared to 0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation: all in-flight vectors are discarded; no output transfer is produced for them.
- Simultaneous input and output transfer in one cycle is legal; the pipeline advances by one stage.
- in_valid while in_ready=0: the data is not accepted; the upstream producer must hold it.
- No combinational path from kernel/patch to res.

Decomposition:
- Package hadamard_pkg:
  - localparams DEF_WIDTH=32 and DEF_SIZE=9.
  - typedef elem_t (logic signed [WIDTH-1:0]).
  - typedef vec_t (packed SIZE array of elem_t) for the defaults.
- Sub-module hadamard_lane:
  - One signed WIDTH x WIDTH multiply truncated to WIDTH bits.
  - Generated SIZE times inside hadamard_product_unit.
  - Stage registers and handshake logic stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0 and res=0 during reset; in_ready=1 after reset; no output appears for vectors presented during reset.
- Basic product: kernel[i]=i+1, patch[i]=2 for i=0..8, out_ready=1 -> exactly 2 cycles later out_valid=1 and res[i]=2*(i+1), i.e. 2,4,...,18.
- Zero/sign: kernel all 0, patch all 0 -> res all 0. Then kernel[0]=-3, patch[0]=7 -> res[0]=32'hFFFFFFEB (-21); kernel[1]=-4, patch[1]=-5 -> res[1]=20.
- Overflow wrap: kernel[0]=32'h0001_0000, patch[0]=32'h0001_0000 -> res[0]=0; kernel[1]=32'h7FFF_FFFF, patch[1]=2 -> res[1]=32'hFFFF_FFFE.
- Backpressure: stream 4 vectors back-to-back, drop out_ready for 3 cycles after the first output -> in_ready=0 during the stall, res stable; all 4 results emerge in order with none lost or duplicated.
- Mid-stream reset: 2 vectors in flight, pulse rst for 1 cycle -> out_valid stays 0 until new inputs are sent; the next vector's result appears 2 cycles after its input transfer.
